// File: rtl/abr_prim_subreg_pkg.sv
// Shared register-access types.
//   sw_access_e : software access policy of a target register (value 3'd7 is unused/illegal)
//   op_e        : register operation requested by a command initiator
//   wfn_e       : write-data function applied when building the bus write
//   op_state_e  : initiator FSM states
package abr_prim_subreg_pkg;

    typedef enum logic [2:0] {
        SwAccessRW  = 3'd0,
        SwAccessRO  = 3'd1,
        SwAccessWO  = 3'd2,
        SwAccessW1C = 3'd3,
        SwAccessW1S = 3'd4,
        SwAccessW0C = 3'd5,
        SwAccessRC  = 3'd6
    } sw_access_e;

    typedef enum logic [1:0] {
        OpRead  = 2'd0,
        OpWrite = 2'd1,
        OpSet   = 2'd2,
        OpClear = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        WdataD         = 2'd0,  // write D (or mask M) unchanged
        WdataNotM      = 2'd1,  // write ~M
        WdataRdOrM     = 2'd2,  // write rdata | M
        WdataRdAndNotM = 2'd3   // write rdata & ~M
    } wfn_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StRsp  = 2'd3
    } op_state_e;

endpackage

// File: rtl/abr_prim_reg_op_decode.sv
// Combinational decode of (op, access policy) into a bus plan.
//   op_i          : requested operation (op_e encoding)
//   acc_i         : access policy of the target register (sw_access_e encoding)
//   illegal_o     : pair is not supported; no bus traffic is generated
//   needs_read_o  : plan starts with a read phase
//   needs_write_o : plan contains a write phase
//   wfn_o         : how the write data is formed
module abr_prim_reg_op_decode
    import abr_prim_subreg_pkg::*;
(
    input  logic [1:0] op_i,
    input  logic [2:0] acc_i,
    output logic       illegal_o,
    output logic       needs_read_o,
    output logic       needs_write_o,
    output wfn_e       wfn_o
);

    always_comb begin
        needs_read_o  = 1'b0;
        needs_write_o = 1'b0;
        wfn_o         = WdataD;
        case (op_i)
            OpRead: begin
                if (acc_i inside {SwAccessRO, SwAccessRW, SwAccessW1C,
                                  SwAccessW1S, SwAccessW0C, SwAccessRC}) begin
                    needs_read_o = 1'b1;
                end
            end
            OpWrite: begin
                if (acc_i inside {SwAccessRW, SwAccessWO}) begin
                    needs_write_o = 1'b1;
                end
            end
            OpSet: begin
                if (acc_i == SwAccessW1S) begin
                    needs_write_o = 1'b1;
                end else if (acc_i == SwAccessRW) begin
                    needs_read_o  = 1'b1;
                    needs_write_o = 1'b1;
                    wfn_o         = WdataRdOrM;
                end
            end
            OpClear: begin
                if (acc_i == SwAccessW1C) begin
                    needs_write_o = 1'b1;
                end else if (acc_i == SwAccessW0C) begin
                    needs_write_o = 1'b1;
                    wfn_o         = WdataNotM;
                end else if (acc_i == SwAccessRW) begin
                    needs_read_o  = 1'b1;
                    needs_write_o = 1'b1;
                    wfn_o         = WdataRdAndNotM;
                end
            end
            default: ;
        endcase
        illegal_o = !(needs_read_o || needs_write_o);
    end

endmodule

// File: rtl/abr_prim_reg_op_initiator.sv
// Turns read/write/set/clear commands into one or two register-bus
// transactions (read-modify-write where the register has no native
// set/clear semantics) and returns a single response per command.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   cmd_*                  : command handshake (valid/ready), op, access policy, address, data/mask
//   bus_req_o/we/addr/wdata: bus request, held until bus_gnt_i
//   bus_gnt_i/rvalid/rdata/err : bus grant and response
//   rsp_*                  : command response (valid/ready), read data, error
module abr_prim_reg_op_initiator
    import abr_prim_subreg_pkg::*;
#(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [1:0]    cmd_op_i,
    input  logic [2:0]    cmd_acc_i,
    input  logic [AW-1:0] cmd_addr_i,
    input  logic [DW-1:0] cmd_data_i,
    output logic          bus_req_o,
    output logic          bus_we_o,
    output logic [AW-1:0] bus_addr_o,
    output logic [DW-1:0] bus_wdata_o,
    input  logic          bus_gnt_i,
    input  logic          bus_rvalid_i,
    input  logic [DW-1:0] bus_rdata_i,
    input  logic          bus_err_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [DW-1:0] rsp_rdata_o,
    output logic          rsp_err_o
);

    function automatic logic [DW-1:0] wdata_fn(input wfn_e          fn,
                                               input logic [DW-1:0] rd,
                                               input logic [DW-1:0] m);
        case (fn)
            WdataD:     return m;
            WdataNotM:  return ~m;
            WdataRdOrM: return rd | m;
            default:    return rd & ~m;
        endcase
    endfunction

    op_state_e     state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;    // D or M as captured at acceptance
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          err_q;
    logic          we_q;      // current bus phase is a write
    logic          rmw_q;     // a write phase follows the read phase
    wfn_e          wfn_q;

    logic dec_illegal, dec_read, dec_write;
    wfn_e dec_wfn;

    abr_prim_reg_op_decode u_decode (
        .op_i          (cmd_op_i),
        .acc_i         (cmd_acc_i),
        .illegal_o     (dec_illegal),
        .needs_read_o  (dec_read),
        .needs_write_o (dec_write),
        .wfn_o         (dec_wfn)
    );

    logic accept;
    logic rsp_in;  // bus response counted only while waiting for it
    assign accept = (state_q == StIdle) && cmd_valid_i;
    assign rsp_in = (state_q == StWait) && bus_rvalid_i;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (cmd_valid_i) state_d = dec_illegal ? StRsp : StReq;
            StReq:  if (bus_gnt_i)   state_d = StWait;
            StWait: begin
                if (bus_rvalid_i) begin
                    state_d = (!we_q && rmw_q && !bus_err_i) ? StReq : StRsp;
                end
            end
            StRsp:  if (rsp_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        cmd_ready_o = (state_q == StIdle);
        bus_req_o   = (state_q == StReq);
        bus_we_o    = (state_q == StReq) && we_q;
        rsp_valid_o = (state_q == StRsp);
    end

    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    // Command capture and per-phase datapath
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            data_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            rmw_q   <= 1'b0;
            wfn_q   <= WdataD;
        end else if (accept) begin
            addr_q  <= cmd_addr_i;
            data_q  <= cmd_data_i;
            wfn_q   <= dec_wfn;
            we_q    <= !dec_read;
            rmw_q   <= dec_read && dec_write;
            rdata_q <= '0;
            err_q   <= dec_illegal;
            // Write-only plans know their data now; RMW data waits for the read.
            wdata_q <= dec_read ? '0 : wdata_fn(dec_wfn, '0, cmd_data_i);
        end else if (rsp_in) begin
            err_q <= err_q | bus_err_i;
            if (!we_q) begin
                rdata_q <= bus_rdata_i;
                if (rmw_q && !bus_err_i) begin
                    we_q    <= 1'b1;
                    wdata_q <= wdata_fn(wfn_q, bus_rdata_i, data_q);
                end
            end
        end
    end

endmodule

// File: tb/tb_abr_prim_reg_op_initiator.sv
module tb_abr_prim_reg_op_initiator;
    import abr_prim_subreg_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [2:0]  cmd_acc = '0;
    logic [15:0] cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic        bus_req, bus_we;
    logic [15:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        bus_err = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    abr_prim_reg_op_initiator #(.AW(16), .DW(32)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_op_i     (cmd_op),
        .cmd_acc_i    (cmd_acc),
        .cmd_addr_i   (cmd_addr),
        .cmd_data_i   (cmd_data),
        .bus_req_o    (bus_req),
        .bus_we_o     (bus_we),
        .bus_addr_o   (bus_addr),
        .bus_wdata_o  (bus_wdata),
        .bus_gnt_i    (bus_gnt),
        .bus_rvalid_i (bus_rvalid),
        .bus_rdata_i  (bus_rdata),
        .bus_err_i    (bus_err),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference plan: which phases an (op, access) pair produces.
    function automatic void model_plan(input logic [1:0] op, input logic [2:0] acc,
                                       output bit rd, output bit wr);
        rd = 1'b0;
        wr = 1'b0;
        if (op == OpRead && acc != 3'd7 && acc != SwAccessWO) rd = 1'b1;
        if (op == OpWrite && (acc == SwAccessRW || acc == SwAccessWO)) wr = 1'b1;
        if (op == OpSet && acc == SwAccessW1S) wr = 1'b1;
        if (op == OpSet && acc == SwAccessRW) begin rd = 1'b1; wr = 1'b1; end
        if (op == OpClear && (acc == SwAccessW1C || acc == SwAccessW0C)) wr = 1'b1;
        if (op == OpClear && acc == SwAccessRW) begin rd = 1'b1; wr = 1'b1; end
    endfunction

    // Reference write value given the register's current value v.
    function automatic logic [31:0] model_wdata(input logic [1:0] op, input logic [2:0] acc,
                                                input logic [31:0] m, input logic [31:0] v);
        if (op == OpSet && acc == SwAccessRW) return v | m;
        if (op == OpClear && acc == SwAccessRW) return v & ~m;
        if (op == OpClear && acc == SwAccessW0C) return ~m;
        return m;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_cmd_ready"}, cmd_ready, 1'b1);
        check_eq({tag, "_bus_req"},   bus_req,   1'b0);
        check_eq({tag, "_bus_we"},    bus_we,    1'b0);
        check_eq({tag, "_bus_addr"},  bus_addr,  16'h0);
        check_eq({tag, "_bus_wdata"}, bus_wdata, 32'h0);
        check_eq({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        check_eq({tag, "_rsp_err"},   rsp_err,   1'b0);
        check_eq({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    endtask

    // Issue one command and play the bus slave / response sink.
    // g: grant wait cycles, r: cycles from grant to rvalid, rdy: rsp_ready delay.
    task automatic run_cmd(input logic [1:0] op, input logic [2:0] acc,
                           input logic [15:0] addr, input logic [31:0] d,
                           input logic [31:0] rdv, input bit rerr, input bit werr,
                           input int unsigned g, input int unsigned r,
                           input int unsigned rdy, input bit junk);
        bit ex_rd, ex_wr, ex_wr_go, ex_err, done, pending, pend_we;
        logic [31:0] ex_wd, ex_rdata;
        int unsigned nphase, ex_lat, k, req_cnt, rv_cnt, rsp_cnt, ntx, first_rsp;
        logic        obs_we[4];
        logic [15:0] obs_addr[4];
        logic [31:0] obs_wd[4];
        logic        hold_we;
        logic [15:0] hold_a;
        logic [31:0] hold_wd, rsp_d0;
        logic        rsp_e0;

        model_plan(op, acc, ex_rd, ex_wr);
        ex_wr_go = ex_wr && !(ex_rd && rerr);
        ex_wd    = model_wdata(op, acc, d, rdv);
        ex_rdata = ex_rd ? rdv : 32'h0;
        ex_err   = (!ex_rd && !ex_wr) || (ex_rd && rerr) || (ex_wr_go && werr);
        nphase   = (ex_rd ? 1 : 0) + (ex_wr_go ? 1 : 0);
        ex_lat   = 1 + nphase * (g + r + 2);

        check_eq("cmd_ready_before", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op = op; cmd_acc = acc; cmd_addr = addr; cmd_data = d;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_acc = 3'($urandom);
        cmd_addr = 16'($urandom); cmd_data = $urandom;

        done = 0; pending = 0; pend_we = 0;
        req_cnt = 0; rv_cnt = 0; rsp_cnt = 0; ntx = 0; first_rsp = 0;
        hold_we = 0; hold_a = '0; hold_wd = '0; rsp_d0 = '0; rsp_e0 = 0;
        k = 1;
        while (!done && k < 200) begin
            if (bus_req) begin
                if (req_cnt == 0) begin
                    hold_we = bus_we; hold_a = bus_addr; hold_wd = bus_wdata;
                end else begin
                    check_eq("req_we_stable",    bus_we,    hold_we);
                    check_eq("req_addr_stable",  bus_addr,  hold_a);
                    check_eq("req_wdata_stable", bus_wdata, hold_wd);
                end
            end
            if (rsp_valid) begin
                if (rsp_cnt == 0) begin
                    first_rsp = k; rsp_d0 = rsp_rdata; rsp_e0 = rsp_err;
                end else begin
                    check_eq("rsp_rdata_stable", rsp_rdata, rsp_d0);
                    check_eq("rsp_err_stable",   rsp_err,   rsp_e0);
                end
            end

            bus_gnt = 0; bus_rvalid = 0; bus_err = 0; bus_rdata = $urandom; rsp_ready = 0;
            if (bus_req) begin
                if (req_cnt == g) begin
                    bus_gnt = 1;
                    if (ntx < 4) begin
                        obs_we[ntx] = bus_we; obs_addr[ntx] = bus_addr; obs_wd[ntx] = bus_wdata;
                    end
                    ntx++;
                    pending = 1; pend_we = bus_we; rv_cnt = 0; req_cnt = 0;
                    if (junk) begin bus_rvalid = 1; bus_err = 1; end
                end else begin
                    req_cnt++;
                end
            end else if (pending) begin
                if (rv_cnt == r) begin
                    bus_rvalid = 1;
                    bus_rdata  = pend_we ? $urandom : rdv;
                    bus_err    = pend_we ? werr : rerr;
                    pending    = 0;
                end else begin
                    rv_cnt++;
                end
            end
            if (rsp_valid) begin
                bus_rvalid = junk;
                bus_err    = junk;
                if (rsp_cnt == rdy) begin
                    rsp_ready = 1; done = 1;
                end else begin
                    rsp_cnt++;
                end
            end
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        bus_gnt = 0; bus_rvalid = 0; bus_err = 0; rsp_ready = 0;

        check_eq("rsp_seen", done, 1'b1);
        check_eq("rsp_latency", first_rsp, ex_lat);
        check_eq("rsp_rdata", rsp_d0, ex_rdata);
        check_eq("rsp_err", rsp_e0, ex_err);
        check_eq("bus_txn_count", ntx, nphase);
        for (int i = 0; i < 2; i++) begin
            if (i < int'(nphase) && i < int'(ntx)) begin
                bit is_wr;
                is_wr = !(ex_rd && i == 0);
                check_eq("txn_we", obs_we[i], is_wr);
                check_eq("txn_addr", obs_addr[i], addr);
                if (is_wr) check_eq("txn_wdata", obs_wd[i], ex_wd);
            end
        end
        check_eq("cmd_ready_after", cmd_ready, 1'b1);
    endtask

    task automatic reset_in_wait();
        cmd_valid = 1; cmd_op = OpRead; cmd_acc = SwAccessRW;
        cmd_addr = 16'hBEEF; cmd_data = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0;
        check_eq("rst_pre_req", bus_req, 1'b1);
        bus_gnt = 1;
        @(posedge clk);
        @(negedge clk);
        bus_gnt = 0;
        rst_n = 0;
        #1;
        check_idle_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1;
        bus_rvalid = 1; bus_rdata = 32'hDEAD_BEEF; bus_err = 1;
        @(posedge clk);
        @(negedge clk);
        bus_rvalid = 0; bus_err = 0;
        for (int i = 0; i < 4; i++) begin
            check_eq("rst_no_rsp", rsp_valid, 1'b0);
            check_eq("rst_no_req", bus_req, 1'b0);
            check_eq("rst_ready", cmd_ready, 1'b1);
            @(negedge clk);
        end
    endtask

    initial begin
        #1;
        check_idle_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check_eq("post_reset_ready", cmd_ready, 1'b1);

        run_cmd(OpClear, SwAccessW1C, 16'h0010, 32'h0000_00F0, 32'h5555_5555, 0, 0, 0, 0, 0, 0);
        run_cmd(OpClear, SwAccessW0C, 16'h0014, 32'h0000_000F, 32'h5555_5555, 0, 0, 0, 0, 0, 0);
        run_cmd(OpSet,   SwAccessRW,  16'h0018, 32'h0000_0100, 32'h0000_0011, 0, 0, 0, 0, 0, 0);
        run_cmd(OpWrite, SwAccessRO,  16'h001C, 32'hCAFE_F00D, 32'h0, 0, 0, 0, 0, 0, 0);
        run_cmd(OpSet,   SwAccessRW,  16'h0020, 32'h0000_0001, 32'h0000_00A0, 1, 0, 0, 0, 0, 0);
        run_cmd(OpRead,  3'd7,        16'h0024, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0);
        run_cmd(OpRead,  SwAccessRC,  16'h0028, 32'h0, 32'h8765_4321, 0, 0, 0, 0, 0, 0);
        run_cmd(OpClear, SwAccessRW,  16'h002C, 32'h0000_FF00, 32'h1234_5678, 0, 1, 4, 2, 3, 1);
        run_cmd(OpWrite, SwAccessWO,  16'h0030, 32'hA5A5_5A5A, 32'h0, 0, 0, 4, 0, 3, 0);

        reset_in_wait();

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                bus_rvalid = 1; bus_err = 1; bus_rdata = $urandom;
                @(posedge clk);
                @(negedge clk);
                bus_rvalid = 0; bus_err = 0;
                check_eq("idle_rvalid_ignored", rsp_valid, 1'b0);
            end
            run_cmd(2'($urandom), 3'($urandom), 16'($urandom), $urandom, $urandom,
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                    $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3),
                    1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
